// File: rtl/roi_pkg.sv
// rtl/roi_pkg.sv - shared widths, config FSM encoding and bounds type for the ROI masker
package roi_pkg;

  localparam int DATA_W_DEF  = 10;
  localparam int COORD_W_DEF = 13;
  localparam int CNT_W_DEF   = 20;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } cfgState_t;

  typedef struct packed {
    logic [COORD_W_DEF-1:0] hmin;
    logic [COORD_W_DEF-1:0] hmax;
    logic [COORD_W_DEF-1:0] vmin;
    logic [COORD_W_DEF-1:0] vmax;
  } bounds_t;

  function automatic logic boundsOk(input bounds_t b);
    return (b.hmin <= b.hmax) && (b.vmin <= b.vmax);
  endfunction

endpackage

// File: rtl/roi_cfg_ctrl.sv
// rtl/roi_cfg_ctrl.sv - bounds handshake, validity check and frame-synchronous apply
module roi_cfg_ctrl
  import roi_pkg::*;
#(
  parameter int H_MIN_RST = 256,
  parameter int H_MAX_RST = 639,
  parameter int V_MIN_RST = 0,
  parameter int V_MAX_RST = 479
) (
  input  logic    iCLK,
  input  logic    iRST,
  input  logic    iFs,
  input  logic    iCfg_Valid,
  input  bounds_t iCfg_Bounds,
  output logic    oCfg_Ready,
  output logic    oCfg_Err,
  output bounds_t oBounds
);

  localparam bounds_t RST_BOUNDS = '{
    hmin: COORD_W_DEF'(H_MIN_RST),
    hmax: COORD_W_DEF'(H_MAX_RST),
    vmin: COORD_W_DEF'(V_MIN_RST),
    vmax: COORD_W_DEF'(V_MAX_RST)
  };

  cfgState_t state;
  bounds_t   activeBounds;
  bounds_t   pendingBounds;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state         <= ST_IDLE;
      activeBounds  <= RST_BOUNDS;
      pendingBounds <= '0;
      oCfg_Ready    <= 1'b1;
      oCfg_Err      <= 1'b0;
    end else begin
      oCfg_Err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iCfg_Valid) begin
            if (boundsOk(iCfg_Bounds)) begin
              pendingBounds <= iCfg_Bounds;
              state         <= ST_PENDING;
              oCfg_Ready    <= 1'b0;
            end else begin
              oCfg_Err <= 1'b1;
            end
          end
        end
        ST_PENDING: begin
          if (iFs) begin
            activeBounds <= pendingBounds;
            state        <= ST_IDLE;
            oCfg_Ready   <= 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          oCfg_Ready <= 1'b1;
        end
      endcase
    end
  end

  // The frame-start pixel already sees the new window, so bypass the register here.
  assign oBounds = (state == ST_PENDING && iFs) ? pendingBounds : activeBounds;

endmodule

// File: rtl/roi_window_mask.sv
// rtl/roi_window_mask.sv - masks RGB pixels outside a programmable 2D ROI and counts in-ROI pixels
// Optional border highlight on the ROI outline when ROI_BORDER_EN is defined.
module roi_window_mask
  import roi_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int COORD_W      = COORD_W_DEF,
  parameter int FILL_VALUE   = 0,
  parameter int H_MIN_RST    = 256,
  parameter int H_MAX_RST    = 639,
  parameter int V_MIN_RST    = 0,
  parameter int V_MAX_RST    = 479,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int BORDER_VALUE = 1023
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iDVAL,
  input  logic [COORD_W-1:0] iH_Cont,
  input  logic [COORD_W-1:0] iV_Cont,
  input  logic [DATA_W-1:0]  iRed,
  input  logic [DATA_W-1:0]  iGreen,
  input  logic [DATA_W-1:0]  iBlue,
  input  logic               iCfg_Valid,
  output logic               oCfg_Ready,
  input  logic [COORD_W-1:0] iCfg_Hmin,
  input  logic [COORD_W-1:0] iCfg_Hmax,
  input  logic [COORD_W-1:0] iCfg_Vmin,
  input  logic [COORD_W-1:0] iCfg_Vmax,
  output logic               oCfg_Err,
  output logic               oDVAL,
  output logic [DATA_W-1:0]  oDATA_R,
  output logic [DATA_W-1:0]  oDATA_G,
  output logic [DATA_W-1:0]  oDATA_B,
  output logic               oIn_ROI,
  output logic               oFrame_Done,
  output logic [CNT_W-1:0]   oROI_Count
);

  localparam logic [DATA_W-1:0] FILL_PIX = DATA_W'(FILL_VALUE);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic              frameStart;
  logic              inWin;
  bounds_t           cfgOffer;
  bounds_t           effBounds;
  logic [DATA_W-1:0] pixR, pixG, pixB;
  logic [CNT_W-1:0]  runCnt;
  logic              seenFrame;

  assign frameStart = iDVAL && (iH_Cont == '0) && (iV_Cont == '0);

  assign cfgOffer = '{hmin: iCfg_Hmin, hmax: iCfg_Hmax, vmin: iCfg_Vmin, vmax: iCfg_Vmax};

  roi_cfg_ctrl #(
    .H_MIN_RST(H_MIN_RST),
    .H_MAX_RST(H_MAX_RST),
    .V_MIN_RST(V_MIN_RST),
    .V_MAX_RST(V_MAX_RST)
  ) uCfg (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iFs        (frameStart),
    .iCfg_Valid (iCfg_Valid),
    .iCfg_Bounds(cfgOffer),
    .oCfg_Ready (oCfg_Ready),
    .oCfg_Err   (oCfg_Err),
    .oBounds    (effBounds)
  );

  assign inWin = (iH_Cont >= effBounds.hmin) && (iH_Cont <= effBounds.hmax) &&
                 (iV_Cont >= effBounds.vmin) && (iV_Cont <= effBounds.vmax);

`ifdef ROI_BORDER_EN
  localparam logic [DATA_W-1:0] BORDER_PIX = DATA_W'(BORDER_VALUE);
  logic onEdge;

  assign onEdge = (iH_Cont == effBounds.hmin) || (iH_Cont == effBounds.hmax) ||
                  (iV_Cont == effBounds.vmin) || (iV_Cont == effBounds.vmax);

  always_comb begin
    pixR = FILL_PIX;
    pixG = FILL_PIX;
    pixB = FILL_PIX;
    if (inWin) begin
      if (iDVAL && onEdge) begin
        pixR = BORDER_PIX;
        pixG = BORDER_PIX;
        pixB = BORDER_PIX;
      end else begin
        pixR = iRed;
        pixG = iGreen;
        pixB = iBlue;
      end
    end
  end
`else
  always_comb begin
    pixR = FILL_PIX;
    pixG = FILL_PIX;
    pixB = FILL_PIX;
    if (inWin) begin
      pixR = iRed;
      pixG = iGreen;
      pixB = iBlue;
    end
  end
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDVAL       <= 1'b0;
      oDATA_R     <= '0;
      oDATA_G     <= '0;
      oDATA_B     <= '0;
      oIn_ROI     <= 1'b0;
      oFrame_Done <= 1'b0;
      oROI_Count  <= '0;
      runCnt      <= '0;
      seenFrame   <= 1'b0;
    end else begin
      oDVAL       <= iDVAL;
      oDATA_R     <= pixR;
      oDATA_G     <= pixG;
      oDATA_B     <= pixB;
      oIn_ROI     <= iDVAL && inWin;
      oFrame_Done <= frameStart && seenFrame;
      // The fs pixel belongs to the new frame: it seeds the count rather than closing the old one.
      if (frameStart) begin
        if (seenFrame) begin
          oROI_Count <= runCnt;
        end
        seenFrame <= 1'b1;
        runCnt    <= inWin ? CNT_W'(1) : '0;
      end else if (iDVAL && inWin && runCnt != CNT_MAX) begin
        runCnt <= runCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_roi_window_mask.sv
// tb/tb_roi_window_mask.sv - directed self-checking bench for roi_window_mask
module tb_roi_window_mask;

  localparam int DW = 10;
  localparam int CW = 13;
  localparam int NW = 20;
  localparam logic [DW-1:0] R0 = 10'h155;
  localparam logic [DW-1:0] G0 = 10'h2AA;
  localparam logic [DW-1:0] B0 = 10'h0F0;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b1;
  logic          iDVAL = 1'b0;
  logic [CW-1:0] iH_Cont = '0;
  logic [CW-1:0] iV_Cont = '0;
  logic [DW-1:0] iRed = '0, iGreen = '0, iBlue = '0;
  logic          iCfg_Valid = 1'b0;
  logic          oCfg_Ready;
  logic [CW-1:0] iCfg_Hmin = '0, iCfg_Hmax = '0, iCfg_Vmin = '0, iCfg_Vmax = '0;
  logic          oCfg_Err;
  logic          oDVAL;
  logic [DW-1:0] oDATA_R, oDATA_G, oDATA_B;
  logic          oIn_ROI;
  logic          oFrame_Done;
  logic [NW-1:0] oROI_Count;

  roi_window_mask dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iH_Cont(iH_Cont), .iV_Cont(iV_Cont),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iCfg_Valid(iCfg_Valid), .oCfg_Ready(oCfg_Ready),
    .iCfg_Hmin(iCfg_Hmin), .iCfg_Hmax(iCfg_Hmax), .iCfg_Vmin(iCfg_Vmin), .iCfg_Vmax(iCfg_Vmax),
    .oCfg_Err(oCfg_Err), .oDVAL(oDVAL), .oDATA_R(oDATA_R), .oDATA_G(oDATA_G), .oDATA_B(oDATA_B),
    .oIn_ROI(oIn_ROI), .oFrame_Done(oFrame_Done), .oROI_Count(oROI_Count)
  );

  always #5 iCLK = ~iCLK;

  int errors = 0;
  int checks = 0;
  int bHmin = 256, bHmax = 639, bVmin = 0, bVmax = 479;
  int rowList[$];
  int expCount = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pixel(input int h, input int v, input logic dval, input logic cv, input logic expDone);
    logic        expIn;
    logic [29:0] expData;
    @(negedge iCLK);
    iDVAL = dval;
    iH_Cont = CW'(h);
    iV_Cont = CW'(v);
    iRed = R0;
    iGreen = G0;
    iBlue = B0;
    iCfg_Valid = cv;
    expIn = (h >= bHmin) && (h <= bHmax) && (v >= bVmin) && (v <= bVmax);
    expData = expIn ? {R0, G0, B0} : 30'd0;
`ifdef ROI_BORDER_EN
    if (expIn && dval && (h == bHmin || h == bHmax || v == bVmin || v == bVmax))
      expData = {3{10'd1023}};
`endif
    @(posedge iCLK);
    #1;
    iCfg_Valid = 1'b0;
    check("dval", oDVAL, dval);
    check("data", {oDATA_R, oDATA_G, oDATA_B}, expData);
    check("in_roi", oIn_ROI, dval && expIn);
    check("frame_done", oFrame_Done, expDone);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pixel(8191, 8191, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input logic expDone, input logic offer);
    for (int r = 0; r < rowList.size(); r++) begin
      for (int h = 0; h < 640; h++) begin
        pixel(h, rowList[r], 1'b1, offer && r == 1 && h == 300, expDone && r == 0 && h == 0);
        if (r == 0 && h == 0) begin
          check("fs_cfg_ready", oCfg_Ready, 1'b1);
          if (expDone) check("roi_count", oROI_Count, expCount);
        end
        if (offer && r == 1 && h == 300) begin
          check("cfg_ready_drop", oCfg_Ready, 1'b0);
          check("cfg_err_quiet", oCfg_Err, 1'b0);
        end
      end
      idle(4);
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge iCLK);
    #1;
    check("rst_dval", oDVAL, 0);
    check("rst_data", {oDATA_R, oDATA_G, oDATA_B}, 0);
    check("rst_in_roi", oIn_ROI, 0);
    check("rst_done", oFrame_Done, 0);
    check("rst_count", oROI_Count, 0);
    check("rst_err", oCfg_Err, 0);
    check("rst_ready", oCfg_Ready, 1);
    @(negedge iCLK);
    iRST = 1'b0;

    // frame A: first fs, no done pulse; rows 479/480 straddle the V bound
    rowList = '{0, 1, 2, 479, 480};
    frame(1'b0, 1'b0);

    // frame B: done with 4*384; offer H 100..199 V 50..59 mid-frame, old bounds stay
    iCfg_Hmin = 13'd100; iCfg_Hmax = 13'd199; iCfg_Vmin = 13'd50; iCfg_Vmax = 13'd59;
    expCount = 1536;
    frame(1'b1, 1'b1);

    // frame C: new window applies from its own fs pixel
    bHmin = 100; bHmax = 199; bVmin = 50; bVmax = 59;
    rowList = '{0, 49, 50, 51, 52, 53, 54, 55, 56, 57, 58, 59, 60};
    expCount = 1536;
    frame(1'b1, 1'b0);

    // frame D: reports the 100x10 window
    rowList = '{0};
    expCount = 1000;
    frame(1'b1, 1'b0);

    // rejected bounds: Hmin > Hmax
    iCfg_Hmin = 13'd300; iCfg_Hmax = 13'd200; iCfg_Vmin = 13'd0; iCfg_Vmax = 13'd10;
    pixel(150, 55, 1'b1, 1'b1, 1'b0);
    check("err_h_pulse", oCfg_Err, 1);
    check("err_h_ready", oCfg_Ready, 1);
    pixel(250, 55, 1'b1, 1'b0, 1'b0);
    check("err_h_single", oCfg_Err, 0);
    pixel(199, 59, 1'b1, 1'b0, 1'b0);
    pixel(200, 59, 1'b1, 1'b0, 1'b0);
    // rejected bounds: Vmin > Vmax
    iCfg_Hmin = 13'd0; iCfg_Hmax = 13'd10; iCfg_Vmin = 13'd20; iCfg_Vmax = 13'd10;
    pixel(8191, 8191, 1'b0, 1'b1, 1'b0);
    check("err_v_pulse", oCfg_Err, 1);
    check("err_v_ready", oCfg_Ready, 1);

    // reset while pending discards the offer
    iCfg_Hmin = 13'd0; iCfg_Hmax = 13'd10; iCfg_Vmin = 13'd0; iCfg_Vmax = 13'd10;
    pixel(8191, 8191, 1'b0, 1'b1, 1'b0);
    check("pend_ready", oCfg_Ready, 0);
    @(negedge iCLK);
    iRST = 1'b1;
    @(posedge iCLK);
    #1;
    check("rst2_ready", oCfg_Ready, 1);
    check("rst2_count", oROI_Count, 0);
    check("rst2_dval", oDVAL, 0);
    @(negedge iCLK);
    iRST = 1'b0;
    bHmin = 256; bHmax = 639; bVmin = 0; bVmax = 479;
    rowList = '{0, 1};
    frame(1'b0, 1'b0);
    rowList = '{0};
    expCount = 768;
    frame(1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/roi_window_mask.md
Name: roi_window_mask

Overview:
- Masks the RGB pixel stream outside a programmable 2D region of interest (ROI). Pixels outside the ROI are replaced with a fill value.
- Sits between the CCD-to-RGB stage and the pupil-search logic.
- Successor to the fixed horizontal-band masker: adds H and V bounds, frame-synchronous reconfiguration via a valid/ready handshake, and a per-frame count of in-ROI pixels.

Parameters:
- DATA_W, 10, bits per colour channel
- COORD_W, 13, width of iH_Cont/iV_Cont
- FILL_VALUE, 0, channel value driven outside the ROI
- H_MIN_RST, 256, reset value of active H lower bound (inclusive)
- H_MAX_RST, 639, reset value of active H upper bound (inclusive)
- V_MIN_RST, 0, reset value of active V lower bound (inclusive)
- V_MAX_RST, 479, reset value of active V upper bound (inclusive)
- CNT_W, 20, width of the ROI pixel counter
- BORDER_VALUE, 1023, channel value for border pixels (used only with ROI_BORDER_EN)

Ports:
- iCLK  in  1  clock
- iRST  in  1  reset; synchronous, active-high
- iDVAL  in  1  input pixel valid
- iH_Cont  in  COORD_W  pixel column
- iV_Cont  in  COORD_W  pixel row
- iRed / iGreen / iBlue  in  DATA_W each  input channels
- iCfg_Valid  in  1  new bounds offered
- oCfg_Ready  out  1  block can accept new bounds
- iCfg_Hmin / iCfg_Hmax / iCfg_Vmin / iCfg_Vmax  in  COORD_W each  offered bounds
- oCfg_Err  out  1  one-cycle pulse: offered bounds rejected
- oDVAL  out  1  output valid
- oDATA_R / oDATA_G / oDATA_B  out  DATA_W each  masked channels
- oIn_ROI  out  1  output pixel is valid and inside the ROI
- oFrame_Done  out  1  one-cycle pulse: oROI_Count updated
- oROI_Count  out  CNT_W  in-ROI pixel count of the last completed frame

Behaviour:
- Reset (iRST=1 at a iCLK edge):
  - all outputs 0, except oCfg_Ready=1.
  - Active bounds load the *_RST values; pending register is cleared.
  - Running count is 0; the seen_frame flag is cleared.
- Pixel path, latency 1 cycle, all outputs registered:
  - oDVAL <= iDVAL, unconditionally.
  - inwin = (Hmin<=H<=Hmax) && (Vmin<=V<=Vmax), all bounds inclusive, unsigned compare.
  - inwin=1: channels pass through. inwin=0: every channel = FILL_VALUE.
  - oIn_ROI <= iDVAL && inwin.
- Frame start (fs): iDVAL=1 && H==0 && V==0.
- Config FSM, states IDLE and PENDING:
  - IDLE: oCfg_Ready=1. On iCfg_Valid=1:
    - If Hmin<=Hmax and Vmin<=Vmax: capture into the pending register and go to PENDING.
    - Otherwise: pulse oCfg_Err for one cycle, stay in IDLE, leave active bounds unchanged.
  - PENDING: oCfg_Ready=0; iCfg_Valid is ignored. On fs: pending copies into active bounds, then return to IDLE. oCfg_Ready returns to 1 the cycle after fs.
  - The fs pixel itself is evaluated with the new bounds (combinational select of pending on the fs cycle).
  - Config offered on the same cycle as fs while in IDLE: accepted into pending, applied at the next fs.
- Counter:
  - Increments on iDVAL && inwin and saturates at 2^CNT_W-1.
  - On fs with seen_frame=1: oROI_Count <= running count (excludes the fs pixel), oFrame_Done pulses aligned with the fs pixel's oDVAL, and running count <= (fs pixel in ROI ? 1 : 0).
  - On the first fs after reset: no pulse, oROI_Count unchanged, seen_frame set, count restarts as above.
- Reset asserted mid-frame or while PENDING: pending config is discarded and the block returns fully to reset values.

Optional Feature:
- Macro: ROI_BORDER_EN.
- Defined: a valid pixel with inwin=1 and (H==Hmin || H==Hmax || V==Vmin || V==Vmax) outputs BORDER_VALUE on all channels. It remains counted and flagged by oIn_ROI.
- Undefined: no border compare logic is generated and BORDER_VALUE is unused; in-ROI pixels pass through unchanged.

Decomposition:
- Package roi_pkg holds:
  - DATA_W/COORD_W/CNT_W defaults
  - the cfg FSM state encoding (ST_IDLE, ST_PENDING)
  - a bounds typedef {hmin,hmax,vmin,vmax}
- Sub-module roi_cfg_ctrl: handshake, validity check, pending/active registers, fs-synchronous apply. It outputs the effective bounds.
- Top level: compare, mux, counter, output registers.

Test Plan:
- Reset, then stream a 640x480 frame of R=G=B=0x155 -> H 256..639 pass with 0x155, H<256 output 0, oDVAL equals iDVAL delayed 1 cycle, no oFrame_Done on the first fs.
- Two full frames with default bounds -> oFrame_Done at the second fs, oROI_Count=384*480=184320.
- Offer bounds H 100..199, V 50..59 mid-frame -> oCfg_Ready drops next cycle; remainder of the frame uses old bounds; next frame passes only the 100x10 window; following oROI_Count=1000.
- Offer Hmin=300, Hmax=200 -> oCfg_Err single pulse, oCfg_Ready stays 1, output unchanged.
- Assert iRST while PENDING -> after reset, bounds are default 256..639/0..479 and oCfg_Ready=1.
- With ROI_BORDER_EN and bounds 10..20/10..20 -> pixel (10,15) outputs 1023, pixel (15,15) passes through, both counted: oROI_Count=121.
